// File: rtl/r_pkt_pkg.sv
// Shared types, widths and helper functions for the r_pkt_gen packet source.
package r_pkt_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HEADER  = 3'd1,
    S_PAYLOAD = 3'd2,
    S_PARITY  = 3'd3,
    S_GAP     = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] hdr_pack(input logic [LEN_W-1:0]  len,
                                                 input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] cur);
    return {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

endpackage

// File: rtl/r_pkt_pattern.sv
// Payload byte generator: incrementing or LFSR sequence started from a seed.
module r_pkt_pattern
  import r_pkt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              advance,
  output logic [DATA_W-1:0] cur_byte,
  output logic [DATA_W-1:0] next_byte
);

  logic mode_q;

  always_comb begin
    next_byte = cur_byte + 8'd1;
    if (mode_q) next_byte = lfsr_next(cur_byte);
  end

  // An all-zero LFSR would lock up, so a zero seed starts the LFSR at 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_byte <= '0;
      mode_q   <= 1'b0;
    end else if (load) begin
      mode_q   <= mode;
      cur_byte <= (mode && seed == '0) ? 8'h01 : seed;
    end else if (advance) begin
      cur_byte <= next_byte;
    end
  end

endmodule

// File: rtl/r_pkt_gen.sv
// Router ingress packet source: header, payload, parity with busy back-pressure.
// Optional macro R_PKT_GEN_PARITY_ERR_INJ_EN enables inverted-parity injection.
module r_pkt_gen
  import r_pkt_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] dest_addr,
  input  logic [LEN_W-1:0]  payload_len,
  input  logic              pat_mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              inj_err,
  input  logic              busy,
  output logic [DATA_W-1:0] data_out,
  output logic              pkt_valid,
  output logic              cmd_ready,
  output logic              cmd_err,
  output logic              done,
  output logic [CNT_W-1:0]  pkts_sent
);

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [DATA_W-1:0] parity;
  logic [3:0]        gap_cnt;
  logic [DATA_W-1:0] inj_mask;
  logic [DATA_W-1:0] pat_cur;
  logic [DATA_W-1:0] pat_next;
  logic              cmd_accept;
  logic              pay_accept;

  assign cmd_accept = (state == S_IDLE) && start && (payload_len != '0);
  assign pay_accept = (state == S_PAYLOAD) && !busy;

`ifdef R_PKT_GEN_PARITY_ERR_INJ_EN
  logic inj_q;
  always_ff @(posedge clk) begin
    if (reset)           inj_q <= 1'b0;
    else if (cmd_accept) inj_q <= inj_err;
  end
  assign inj_mask = {DATA_W{inj_q}};
`else
  logic unused_inj;
  assign unused_inj = inj_err;
  assign inj_mask   = '0;
`endif

  r_pkt_pattern u_pattern (
    .clk       (clk),
    .reset     (reset),
    .load      (cmd_accept),
    .mode      (pat_mode),
    .seed      (seed),
    .advance   (pay_accept),
    .cur_byte  (pat_cur),
    .next_byte (pat_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      idx       <= '0;
      parity    <= '0;
      gap_cnt   <= '0;
      data_out  <= '0;
      pkt_valid <= 1'b0;
      cmd_ready <= 1'b1;
      cmd_err   <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= '0;
    end else begin
      done    <= 1'b0;
      cmd_err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (payload_len == '0) begin
              cmd_err <= 1'b1;
            end else begin
              len_q     <= payload_len;
              idx       <= '0;
              parity    <= hdr_pack(payload_len, dest_addr);
              data_out  <= hdr_pack(payload_len, dest_addr);
              pkt_valid <= 1'b1;
              cmd_ready <= 1'b0;
              state     <= S_HEADER;
            end
          end
        end
        S_HEADER: begin
          if (!busy) begin
            data_out <= pat_cur;
            state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          // data_out already holds the byte being accepted; fold it in here.
          if (!busy) begin
            idx    <= idx + 6'd1;
            parity <= parity ^ data_out;
            if (idx == len_q - 6'd1) begin
              data_out  <= (parity ^ data_out) ^ inj_mask;
              pkt_valid <= 1'b0;
              state     <= S_PARITY;
            end else begin
              data_out <= pat_next;
            end
          end
        end
        S_PARITY: begin
          if (!busy) begin
            pkts_sent <= pkts_sent + CNT_W'(1);
            data_out  <= '0;
            gap_cnt   <= '0;
            if (GAP_CYCLES == 0) begin
              cmd_ready <= 1'b1;
              done      <= 1'b1;
              state     <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            cmd_ready <= 1'b1;
            done      <= 1'b1;
            state     <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          pkt_valid <= 1'b0;
          data_out  <= '0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_r_pkt_gen.sv
// Directed self-checking bench for r_pkt_gen with hand-computed byte sequences.
module tb_r_pkt_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  dest_addr;
  logic [5:0]  payload_len;
  logic        pat_mode;
  logic [7:0]  seed;
  logic        inj_err;
  logic        busy;
  logic [7:0]  data_out;
  logic        pkt_valid;
  logic        cmd_ready;
  logic        cmd_err;
  logic        done;
  logic [15:0] pkts_sent;

  int checks = 0;
  int errors = 0;

  r_pkt_gen #(.GAP_CYCLES(2), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dest_addr   (dest_addr),
    .payload_len (payload_len),
    .pat_mode    (pat_mode),
    .seed        (seed),
    .inj_err     (inj_err),
    .busy        (busy),
    .data_out    (data_out),
    .pkt_valid   (pkt_valid),
    .cmd_ready   (cmd_ready),
    .cmd_err     (cmd_err),
    .done        (done),
    .pkts_sent   (pkts_sent)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [1:0] a, input logic [5:0] l, input logic m,
                     input logic [7:0] s, input logic inj);
    dest_addr   = a;
    payload_len = l;
    pat_mode    = m;
    seed        = s;
    inj_err     = inj;
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  // Emits a command, then checks every byte, the gap, done and the counter.
  task automatic run_pkt(input string tag, input logic [1:0] a, input logic [5:0] l,
                         input logic m, input logic [7:0] s, input logic inj,
                         input logic [7:0] exp_bytes[8], input int n,
                         input logic [15:0] exp_cnt);
    cmd(a, l, m, s, inj);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_byte"}, 32'(data_out), 32'(exp_bytes[i]));
      chk({tag, "_valid"}, 32'(pkt_valid), (i < n - 1) ? 32'd1 : 32'd0);
      tick();
    end
    chk({tag, "_gap_data"}, 32'(data_out), 32'd0);
    chk({tag, "_gap_valid"}, 32'(pkt_valid), 32'd0);
    chk({tag, "_gap_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, "_cnt"}, 32'(pkts_sent), 32'(exp_cnt));
    tick();
    chk({tag, "_gap2_done"}, 32'(done), 32'd0);
    tick();
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  logic [7:0] basic_b[8];
  logic [7:0] lfsr_b[8];
  logic [7:0] inj_b[8];

  initial begin
    reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0;
    pat_mode = 1'b0; seed = '0; inj_err = 1'b0; busy = 1'b0;
    basic_b = '{8'h0E, 8'hA0, 8'hA1, 8'hA2, 8'hAD, 8'h00, 8'h00, 8'h00};
    lfsr_b  = '{8'h14, 8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h0A, 8'h00};
`ifdef R_PKT_GEN_PARITY_ERR_INJ_EN
    inj_b   = '{8'h0E, 8'hA0, 8'hA1, 8'hA2, 8'h52, 8'h00, 8'h00, 8'h00};
`else
    inj_b   = '{8'h0E, 8'hA0, 8'hA1, 8'hA2, 8'hAD, 8'h00, 8'h00, 8'h00};
`endif
    tick(); tick();
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_valid", 32'(pkt_valid), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_cnt", 32'(pkts_sent), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    reset = 1'b0;
    tick();

    run_pkt("basic", 2'd2, 6'd3, 1'b0, 8'hA0, 1'b0, basic_b, 5, 16'd1);

    // Stall: busy for three edges while A1 is presented.
    cmd(2'd2, 6'd3, 1'b0, 8'hA0, 1'b0);
    chk("stall_hdr", 32'(data_out), 32'h0E);
    tick();
    chk("stall_a0", 32'(data_out), 32'hA0);
    tick();
    chk("stall_a1", 32'(data_out), 32'hA1);
    busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 32'(data_out), 32'hA1);
      chk("stall_hold_v", 32'(pkt_valid), 32'd1);
    end
    busy = 1'b0;
    tick();
    chk("stall_a2", 32'(data_out), 32'hA2);
    tick();
    chk("stall_par", 32'(data_out), 32'hAD);
    chk("stall_par_v", 32'(pkt_valid), 32'd0);
    tick();
    chk("stall_cnt", 32'(pkts_sent), 32'd2);
    tick(); tick();
    chk("stall_done", 32'(done), 32'd1);
    tick();

    run_pkt("lfsr", 2'd0, 6'd5, 1'b1, 8'h01, 1'b0, lfsr_b, 7, 16'd3);

    // Zero length command is rejected.
    cmd(2'd1, 6'd0, 1'b0, 8'h33, 1'b0);
    chk("zero_err", 32'(cmd_err), 32'd1);
    chk("zero_ready", 32'(cmd_ready), 32'd1);
    chk("zero_valid", 32'(pkt_valid), 32'd0);
    tick();
    chk("zero_err_clr", 32'(cmd_err), 32'd0);
    chk("zero_valid2", 32'(pkt_valid), 32'd0);

    // Start held high after acceptance must not restart or reload the packet.
    cmd(2'd2, 6'd3, 1'b0, 8'hA0, 1'b0);
    start = 1'b1; seed = 8'h55;
    tick();
    chk("ign_a0", 32'(data_out), 32'hA0);
    tick();
    start = 1'b0;
    chk("ign_a1", 32'(data_out), 32'hA1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(pkt_valid), 32'd0);
    chk("mid_rst_data", 32'(data_out), 32'd0);
    chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_cnt", 32'(pkts_sent), 32'd0);
    tick();
    chk("mid_rst_idle", 32'(data_out), 32'd0);

    run_pkt("post_rst", 2'd2, 6'd3, 1'b0, 8'hA0, 1'b0, basic_b, 5, 16'd1);
    run_pkt("inj", 2'd2, 6'd3, 1'b0, 8'hA0, 1'b1, inj_b, 5, 16'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/r_pkt_gen.md
Name: r_pkt_gen

Overview:
- Packet source driving the router's input port: the transmit end of the router ingress protocol.
- Accepts a command (destination, length, payload pattern) and emits the packet: header byte, then payload bytes, then parity byte.
- Honours the router's busy back-pressure.
- Used as on-chip traffic generator/BIST source in front of the 1x4 router.

Parameters:
GAP_CYCLES, 2, idle cycles (0..15) inserted after each parity byte before the next command is accepted
CNT_W, 16, width of the sent-packet counter

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  command strobe, sampled only when cmd_ready=1
dest_addr  input  2  destination output port 0..3
payload_len  input  6  payload byte count, 1..63
pat_mode  input  1  0 = incrementing from seed, 1 = LFSR from seed
seed  input  8  first payload byte / LFSR seed
inj_err  input  1  parity corruption request (see Optional Feature)
busy  input  1  router back-pressure; transfer stalls while high
data_out  output  8  byte to router
pkt_valid  output  1  high during header and payload bytes; low on the parity byte
cmd_ready  output  1  high in IDLE
cmd_err  output  1  one-cycle pulse when start is given with payload_len=0
done  output  1  one-cycle pulse on the cycle the FSM returns to IDLE after a packet
pkts_sent  output  CNT_W  count of completed packets, wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs are registered and reset to 0, except cmd_ready=1. State returns to IDLE.
- Reset mid-packet aborts immediately: pkt_valid=0 and data_out=0 on the next cycle; no parity byte is sent.
- Transfer rule: a byte is presented for at least one cycle and is "accepted" at a rising edge where busy=0. While busy=1, data_out and pkt_valid hold unchanged.
- IDLE:
  - cmd_ready=1, pkt_valid=0, data_out=0.
  - start with payload_len!=0: latch all command fields; next cycle go to HEADER.
  - start with payload_len=0: pulse cmd_err, stay IDLE.
- HEADER:
  - data_out = {payload_len, dest_addr}, pkt_valid=1.
  - parity register loads the header byte.
  - On accept, go to PAYLOAD with byte index 0.
- PAYLOAD:
  - data_out = current pattern byte, pkt_valid=1.
  - On accept: XOR the byte into parity and increment the index.
  - After byte payload_len-1 is accepted, go to PARITY.
- Payload patterns:
  - Incrementing: byte i = seed + i, mod 256.
  - LFSR: byte 0 = seed, with seed 0 replaced by 8'h01. Next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
- PARITY:
  - data_out = XOR of header and all payload bytes, pkt_valid=0.
  - On accept: increment pkts_sent and go to GAP.
- GAP:
  - data_out=0, pkt_valid=0, held for GAP_CYCLES cycles, ignoring busy.
  - Then go to IDLE and pulse done in that first IDLE cycle.
  - If GAP_CYCLES=0, go directly from PARITY to IDLE.
- start during a non-IDLE state is ignored.
- busy asserted in the same cycle as start has no effect on command acceptance; it only stalls the header.

Optional Feature:
- Macro R_PKT_GEN_PARITY_ERR_INJ_EN.
- Defined: inj_err is latched with the command; if set, the parity byte is transmitted bit-inverted (~parity).
- Undefined: the inj_err port is present but ignored, and parity is always correct.

Decomposition:
- Package r_pkt_pkg holds:
  - state enum (IDLE, HEADER, PAYLOAD, PARITY, GAP)
  - header pack function
  - LFSR next-state function
  - ADDR_W=2, LEN_W=6, DATA_W=8 constants
- One sub-module, r_pkt_pattern: holds the current payload byte, loads from seed on command accept, advances on payload accept per pat_mode.

Test Plan:
- Basic packet: addr=2, len=3, pat_mode=0, seed=8'hA0, busy=0 → data_out sequence 0E (pkt_valid=1), A0, A1, A2 (pkt_valid=1), AD (pkt_valid=0); then 2 gap cycles; done pulse; pkts_sent=1.
- Stall: same packet with busy=1 for 3 cycles while A1 is presented → A1 held 4 cycles; rest of sequence and parity AD unchanged.
- LFSR: pat_mode=1, seed=8'h01, len=5, addr=0 → header 14; payload 01,02,04,08,11; parity = XOR of all six bytes.
- Zero length: start with len=0 → cmd_err pulses one cycle, pkt_valid stays 0, cmd_ready stays 1.
- Reset mid-packet: reset asserted while payload byte 1 is presented → next cycle pkt_valid=0, data_out=0, IDLE, pkts_sent=0; a new command then runs a clean packet.
- Error injection (macro defined): basic packet with inj_err=1 → parity byte 52. With the macro undefined → parity byte AD.
